// File: rtl/fir_bank_scheduler_if.sv
// Sample handshake, coefficient-memory port and result bus of the shared-MAC filter bank.
// FIR_CH_MASK_EN adds the per-channel enable input ch_en.
interface fir_bank_scheduler_if #(
  parameter int NTAPS = 16,
  parameter int NCH   = 4,
  parameter int DW    = 16,
  parameter int CW    = 16
);
  localparam int AW = $clog2(NCH * NTAPS);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 out_valid;
  logic signed [DW-1:0] LP_out;
  logic signed [DW-1:0] HP_out;
  logic signed [DW-1:0] BP_out;
  logic signed [DW-1:0] MA_out;
`ifdef FIR_CH_MASK_EN
  logic [NCH-1:0]       ch_en;
`endif

  modport master (
    output in_valid, in, coef_data,
    input  in_ready, coef_addr, out_valid, LP_out, HP_out, BP_out, MA_out
`ifdef FIR_CH_MASK_EN
    , output ch_en
`endif
  );

  modport slave (
    input  in_valid, in, coef_data,
    output in_ready, coef_addr, out_valid, LP_out, HP_out, BP_out, MA_out
`ifdef FIR_CH_MASK_EN
    , input ch_en
`endif
  );
endinterface

// File: rtl/fir_bank_scheduler.sv
// Four FIR channels (LP, HP, BP, MA) sharing one delay line and one MAC over a sync coefficient ROM.
// Optional FIR_CH_MASK_EN: ch_en selects which channels are computed for each accepted sample.
//
// state | meaning
// IDLE  | waiting for a sample, in_ready=1
// RUN   | one coefficient fetch per cycle over all taps of each enabled channel
// DRAIN | last product completes; returns to IDLE with out_valid
module fir_bank_scheduler #(
  parameter int NTAPS = 16,
  parameter int NCH   = 4,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int ACCW  = 40,
  parameter int SHIFT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_bank_scheduler_if.slave  bus
);
  localparam int AW  = $clog2(NCH * NTAPS);
  localparam int TW  = $clog2(NTAPS);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [TW-1:0]          TAP_LAST = TW'(NTAPS - 1);
  localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SMIN = ~SMAX;
  localparam logic signed [DW-1:0]   DMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]   DMIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t         state, state_nx;
  logic [CHW-1:0] ch, ch_nx;
  logic [TW-1:0]  tap, tap_nx;
  logic [NCH-1:0] en_q, en_nx, ch_mask;
  logic           out_valid, ov_nx, mac_nx;
  logic [CHW:0]   first_sel, succ_sel;
  logic           accept;

`ifdef FIR_CH_MASK_EN
  assign ch_mask = bus.ch_en;
`else
  assign ch_mask = '1;
`endif

  // {found, index} of the lowest set bit of m at or above position from
  function automatic logic [CHW:0] next_en(input logic [NCH-1:0] m, input int from);
    logic [CHW:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (m[i] && i >= from) r = {1'b1, CHW'(i)};
    return r;
  endfunction

  assign first_sel = next_en(ch_mask, 0);
  assign succ_sel  = next_en(en_q, int'(ch) + 1);
  assign accept    = bus.in_valid && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ch        <= '0;
      tap       <= '0;
      en_q      <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      ch        <= ch_nx;
      tap       <= tap_nx;
      en_q      <= en_nx;
      out_valid <= ov_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ch_nx    = ch;
    tap_nx   = tap;
    en_nx    = en_q;
    ov_nx    = 1'b0;
    mac_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          en_nx    = ch_mask;
          tap_nx   = '0;
          ch_nx    = first_sel[CHW-1:0];
          state_nx = first_sel[CHW] ? RUN : DRAIN;
        end
      end
      RUN: begin
        mac_nx = 1'b1;
        if (tap == TAP_LAST) begin
          tap_nx = '0;
          if (succ_sel[CHW]) ch_nx = succ_sel[CHW-1:0];
          else               state_nx = DRAIN;
        end else begin
          tap_nx = tap + 1'b1;
        end
      end
      DRAIN: begin
        ov_nx    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid;
  assign bus.coef_addr = (state == RUN) ? AW'(ch) * AW'(NTAPS) + AW'(tap) : '0;

  // MAC runs one cycle behind the address because the coefficient memory is synchronous
  logic signed [DW-1:0]   x [NTAPS];
  logic signed [DW-1:0]   res [NCH];
  logic signed [DW-1:0]   out_q [NCH];
  logic signed [ACCW-1:0] acc, prod, acc_nx, shifted;
  logic signed [DW-1:0]   sat_val;
  logic [TW-1:0]          tap_d;
  logic [CHW-1:0]         ch_d;
  logic                   mac_v, last_d;

  assign last_d = mac_v && (tap_d == TAP_LAST);

  always_comb begin
    prod    = ACCW'(bus.coef_data) * ACCW'(x[tap_d]);
    acc_nx  = ((tap_d == '0) ? '0 : acc) + prod;
    shifted = acc_nx >>> SHIFT;
    if (shifted > SMAX)      sat_val = DMAX;
    else if (shifted < SMIN) sat_val = DMIN;
    else                     sat_val = shifted[DW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) x[k] <= '0;
      for (int c = 0; c < NCH; c++) begin
        res[c]   <= '0;
        out_q[c] <= '0;
      end
      acc   <= '0;
      tap_d <= '0;
      ch_d  <= '0;
      mac_v <= 1'b0;
    end else begin
      mac_v <= mac_nx;
      tap_d <= tap;
      ch_d  <= ch;
      if (accept) begin
        x[0] <= bus.in;
        for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
      end
      if (mac_v) acc <= acc_nx;
      if (last_d) res[ch_d] <= sat_val;
      // final channel's result is still in flight on the out_valid edge, so bypass it
      if (ov_nx) begin
        for (int c = 0; c < NCH; c++) begin
          if (!en_q[c])                           out_q[c] <= '0;
          else if (last_d && ch_d == CHW'(c))     out_q[c] <= sat_val;
          else                                    out_q[c] <= res[c];
        end
      end
    end
  end

  assign bus.LP_out = out_q[0];
  assign bus.HP_out = out_q[1];
  assign bus.BP_out = out_q[2];
  assign bus.MA_out = out_q[3];
endmodule
